// File: rtl/multiplicador_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiply-accumulate unit.
// The state encoding lives here so checkers can decode the debug state output.
package mult_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/multiplicador_shift_add.sv
// Sequential unsigned multiply-accumulate: P = A_in*B_in + C_in, one multiplier bit per cycle.
// Handshake: start is sampled only in IDLE; busy covers RUN and DONE; done is a one-cycle pulse with P valid.
module multiplicador_shift_add
    import mult_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   A_in,
    input  logic [W-1:0]   B_in,
    input  logic [W-1:0]   C_in,
    output logic [2*W-1:0] P,
    output logic           busy,
    output logic           done,
    output mult_state_t    state_dbg
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    mult_state_t    state;
    mult_state_t    state_nx;
    logic [2*W-1:0] a_sh;
    logic [W-1:0]   b_sh;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nx;
    logic [CW-1:0]  cnt;
    logic           last_iter;

    // The last iteration's add must reach P in the same edge that enters DONE.
    assign acc_nx    = b_sh[0] ? (acc + a_sh) : acc;
    assign last_iter = (cnt == CW'(W - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= {{W{1'b0}}, A_in};
                        b_sh <= B_in;
                        acc  <= {{W{1'b0}}, C_in};
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_nx;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) P <= acc_nx;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == RUN) || (state == DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_multiplicador_shift_add.sv
// Self-checking bench for multiplicador_shift_add: cycle-level timing model plus directed literal checks.
module tb_multiplicador_shift_add;
    import mult_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic [W-1:0]   c_in = '0;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;
    mult_state_t    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    multiplicador_shift_add #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A_in      (a_in),
        .B_in      (b_in),
        .C_in      (c_in),
        .P         (p),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Timing model: an accepted start at edge k gives done at edge k+W,
    // busy over edges k..k+W, and the next acceptance no earlier than k+W+2.
    int             cyc     = 0;
    int             acc_at  = -1;
    int             done_at = -1;
    int             free_at = 0;
    logic [2*W-1:0] exp_p   = '0;
    logic [2*W-1:0] exp_q[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_at  = -1;
            done_at = -1;
            free_at = cyc + 1;
            exp_p   = '0;
        end else begin
            if (done_at == cyc && exp_q.size() > 0) exp_p = exp_q.pop_front();
            if (start && cyc >= free_at) begin
                acc_at  = cyc;
                done_at = cyc + W;
                free_at = cyc + W + 2;
                exp_q.push_back((2*W)'(a_in) * (2*W)'(b_in) + (2*W)'(c_in));
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_done", {31'b0, done}, {31'b0, (cyc == done_at)});
            chk("model_busy", {31'b0, busy},
                {31'b0, (acc_at >= 0 && cyc >= acc_at && cyc <= done_at)});
            chk("model_p", {16'b0, p}, {16'b0, exp_p});
        end
    end

    // Drive operands right after an edge, let the next edge accept, then wait for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input int exp_lit, input string name);
        int k;
        int lat;
        bit seen;
        @(posedge clk);
        #2;
        a_in = a; b_in = b; c_in = c; start = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        #1 start = 1'b0;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = cyc - k;
                break;
            end
        end
        chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({name, "_latency"}, lat, W);
        chk({name, "_p"}, {16'b0, p}, exp_lit);
        @(posedge clk);
    endtask

    initial begin
        int done_cycles[$];
        int a;
        int b;
        int c;
        bit any_done;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_p", {16'b0, p}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_state", {30'b0, state_dbg}, {30'b0, IDLE});
        #1 rst = 1'b0;

        run_op(8'd1,   8'd40,  8'd24,  64,    "d1_40_24");
        run_op(8'd5,   8'd10,  8'd5,   55,    "d5_10_5");
        run_op(8'd4,   8'd3,   8'd1,   13,    "d4_3_1");
        run_op(8'd12,  8'd8,   8'd3,   99,    "d12_8_3");
        run_op(8'd255, 8'd255, 8'd255, 65280, "max");
        run_op(8'd0,   8'd200, 8'd0,   0,     "a_zero");
        run_op(8'd200, 8'd0,   8'd7,   7,     "b_zero");

        // Start held high: back-to-back operations every W+2 cycles.
        @(posedge clk);
        #2;
        a_in = 8'd3; b_in = 8'd3; c_in = 8'd0; start = 1'b1;
        for (int i = 0; i < 3*(W+2) + 2; i++) begin
            @(negedge clk);
            if (done) begin
                done_cycles.push_back(cyc);
                chk("held_p", {16'b0, p}, 32'd9);
            end
        end
        @(posedge clk);
        #2 start = 1'b0;
        chk("held_pulses", done_cycles.size(), 3);
        for (int i = 1; i < done_cycles.size(); i++)
            chk("held_period", done_cycles[i] - done_cycles[i-1], W + 2);
        repeat (W + 3) @(posedge clk);

        // Second start during RUN must be ignored.
        @(posedge clk);
        #2;
        a_in = 8'd2; b_in = 8'd2; c_in = 8'd0; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        a_in = 8'd9; b_in = 8'd9; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 20 && !any_done; i++) begin
            @(negedge clk);
            if (done) begin
                any_done = 1'b1;
                chk("repulse_p", {16'b0, p}, 32'd4);
            end else begin
                chk("repulse_busy", {31'b0, busy}, 32'd1);
            end
        end
        chk("repulse_done_seen", {31'b0, any_done}, 32'd1);
        repeat (2) @(posedge clk);
        chk("repulse_no_second_op", {31'b0, busy}, 32'd0);

        // Reset mid-run aborts without a done pulse.
        @(posedge clk);
        #2;
        a_in = 8'd7; b_in = 8'd7; c_in = 8'd0; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_p", {16'b0, p}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        #1 rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        chk("abort_no_done", {31'b0, any_done}, 32'd0);
        run_op(8'd6, 8'd7, 8'd0, 42, "after_abort");

        for (int n = 0; n < 200; n++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            c = $urandom_range(0, 255);
            run_op(a[W-1:0], b[W-1:0], c[W-1:0], a * b + c, "rand");
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
